// File: rtl/syn_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : syn_sram_arb_if
// Brief    : GPU, VGA and external-SRAM signal bundle for syn_sram_arb.
// Revision : 1.0
// ============================================================================
interface syn_sram_arb_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              gpu_req_i;
  logic              gpu_we_i;
  logic [ADDR_W-1:0] gpu_addr_i;
  logic [DATA_W-1:0] gpu_wdata_i;
  logic              gpu_gnt_o;
  logic              gpu_rd_valid_o;
  logic [DATA_W-1:0] gpu_rdata_o;

  logic              vga_req_i;
  logic [ADDR_W-1:0] vga_addr_i;
  logic              vga_gnt_o;
  logic              vga_rd_valid_o;
  logic [DATA_W-1:0] vga_rdata_o;

  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_wdata_o;
  logic              sram_we_o;
  logic              sram_oe_o;
  logic [DATA_W-1:0] sram_rdata_i;

  // Requesters and the SRAM device model.
  modport master (
    output gpu_req_i, gpu_we_i, gpu_addr_i, gpu_wdata_i,
    output vga_req_i, vga_addr_i,
    output sram_rdata_i,
    input  gpu_gnt_o, gpu_rd_valid_o, gpu_rdata_o,
    input  vga_gnt_o, vga_rd_valid_o, vga_rdata_o,
    input  sram_addr_o, sram_wdata_o, sram_we_o, sram_oe_o
  );

  // The arbiter.
  modport slave (
    input  gpu_req_i, gpu_we_i, gpu_addr_i, gpu_wdata_i,
    input  vga_req_i, vga_addr_i,
    input  sram_rdata_i,
    output gpu_gnt_o, gpu_rd_valid_o, gpu_rdata_o,
    output vga_gnt_o, vga_rd_valid_o, vga_rdata_o,
    output sram_addr_o, sram_wdata_o, sram_we_o, sram_oe_o
  );
endinterface
`default_nettype wire

// File: rtl/syn_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : syn_sram_arb
// Brief    : VGA-priority SRAM arbiter with GPU starvation guard, write-to-read
//            turnaround bubble and owner-tagged read return.
// Revision : 1.0
// ============================================================================
module syn_sram_arb #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 2,
  parameter int GPU_MAX_WAIT = 8
) (
  input  wire           clk_ir,
  input  wire           rst_ih,
  syn_sram_arb_if.slave bus
);

  localparam logic [7:0] C_MAX_WAIT = 8'(GPU_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_wait_cnt;

  logic              w_force;
  logic              w_gpu_win;
  logic              w_vga_win;
  logic              w_cand_rd;
  logic              w_turn;
  logic              w_gpu_gnt;
  logic              w_vga_gnt;

  logic              r_sram_we;
  logic              r_sram_oe;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic              r_rd_gpu;

  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_gpu;

  logic              r_gpu_rd_valid;
  logic [DATA_W-1:0] r_gpu_rdata;
  logic              r_vga_rd_valid;
  logic [DATA_W-1:0] r_vga_rdata;

  always_comb begin
    w_force     = (r_wait_cnt == C_MAX_WAIT);
    w_gpu_win   = bus.gpu_req_i && (!bus.vga_req_i || w_force);
    w_vga_win   = bus.vga_req_i && !w_gpu_win;
    w_cand_rd   = w_vga_win || (w_gpu_win && !bus.gpu_we_i);
    // A read directly behind a write must wait one idle cycle for the bus.
    w_turn      = (r_state == WR) && w_cand_rd;
    w_gpu_gnt   = w_gpu_win && !w_turn && !rst_ih;
    w_vga_gnt   = w_vga_win && !w_turn && !rst_ih;

    w_state_nxt = IDLE;
    if (w_turn) begin
      w_state_nxt = TURN;
    end else if (w_gpu_gnt) begin
      w_state_nxt = bus.gpu_we_i ? WR : RD;
    end else if (w_vga_gnt) begin
      w_state_nxt = RD;
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_wait_cnt <= 8'd0;
    end else if (!bus.gpu_req_i || w_gpu_gnt) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt != C_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_sram_we    <= 1'b0;
      r_sram_oe    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_rd_gpu     <= 1'b0;
    end else begin
      r_sram_we <= w_gpu_gnt && bus.gpu_we_i;
      r_sram_oe <= w_vga_gnt || (w_gpu_gnt && !bus.gpu_we_i);
      if (w_vga_gnt) begin
        r_sram_addr <= bus.vga_addr_i;
        r_rd_gpu    <= 1'b0;
      end else if (w_gpu_gnt) begin
        r_sram_addr <= bus.gpu_addr_i;
        r_rd_gpu    <= 1'b1;
        if (bus.gpu_we_i) begin
          r_sram_wdata <= bus.gpu_wdata_i;
        end
      end
    end
  end

  // Tags enter alongside the read strobe and leave when the SRAM data is valid.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_tag_vld <= '0;
      r_tag_gpu <= '0;
    end else begin
      r_tag_vld[0] <= r_sram_oe;
      r_tag_gpu[0] <= r_rd_gpu;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_gpu[i] <= r_tag_gpu[i-1];
      end
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      r_gpu_rd_valid <= 1'b0;
      r_gpu_rdata    <= '0;
      r_vga_rd_valid <= 1'b0;
      r_vga_rdata    <= '0;
    end else begin
      r_gpu_rd_valid <= r_tag_vld[RD_LAT-1] && r_tag_gpu[RD_LAT-1];
      r_vga_rd_valid <= r_tag_vld[RD_LAT-1] && !r_tag_gpu[RD_LAT-1];
      if (r_tag_vld[RD_LAT-1] && r_tag_gpu[RD_LAT-1]) begin
        r_gpu_rdata <= bus.sram_rdata_i;
      end
      if (r_tag_vld[RD_LAT-1] && !r_tag_gpu[RD_LAT-1]) begin
        r_vga_rdata <= bus.sram_rdata_i;
      end
    end
  end

  assign bus.gpu_gnt_o      = w_gpu_gnt;
  assign bus.vga_gnt_o      = w_vga_gnt;
  assign bus.gpu_rd_valid_o = r_gpu_rd_valid;
  assign bus.gpu_rdata_o    = r_gpu_rdata;
  assign bus.vga_rd_valid_o = r_vga_rd_valid;
  assign bus.vga_rdata_o    = r_vga_rdata;
  assign bus.sram_addr_o    = r_sram_addr;
  assign bus.sram_wdata_o   = r_sram_wdata;
  assign bus.sram_we_o      = r_sram_we;
  assign bus.sram_oe_o      = r_sram_oe;

endmodule
`default_nettype wire

// File: tb/tb_syn_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_sram_arb
// Brief    : Directed vector table plus starvation and reset-mid-read sequences.
// Revision : 1.0
// ============================================================================
module tb_syn_sram_arb;

  localparam int NV = 28;
  localparam int D  = 'hDEAD;

  // Inputs (gr..rd) then outputs expected in the same cycle (eg..evd).
  typedef struct {
    int gr, gw, ga, gd, vr, va, rd;
    int eg, ev, ewe, eoe, ea, ed, egv, egd, evv, evd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [NV];

  syn_sram_arb_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  syn_sram_arb #(
    .ADDR_W(18), .DATA_W(16), .RD_LAT(2), .GPU_MAX_WAIT(8)
  ) dut (
    .clk_ir (clk),
    .rst_ih (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int gr, gw, ga, gd, vr, va, rd);
    bus.gpu_req_i    = gr[0];
    bus.gpu_we_i     = gw[0];
    bus.gpu_addr_i   = 18'(ga);
    bus.gpu_wdata_i  = 16'(gd);
    bus.vga_req_i    = vr[0];
    bus.vga_addr_i   = 18'(va);
    bus.sram_rdata_i = 16'(rd);
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " gpu_gnt"},   int'(bus.gpu_gnt_o),      v.eg);
    chk({tag, " vga_gnt"},   int'(bus.vga_gnt_o),      v.ev);
    chk({tag, " sram_we"},   int'(bus.sram_we_o),      v.ewe);
    chk({tag, " sram_oe"},   int'(bus.sram_oe_o),      v.eoe);
    chk({tag, " sram_addr"}, int'(bus.sram_addr_o),    v.ea);
    chk({tag, " sram_wdata"},int'(bus.sram_wdata_o),   v.ed);
    chk({tag, " gpu_vld"},   int'(bus.gpu_rd_valid_o), v.egv);
    chk({tag, " gpu_rdata"}, int'(bus.gpu_rdata_o),    v.egd);
    chk({tag, " vga_vld"},   int'(bus.vga_rd_valid_o), v.evv);
    chk({tag, " vga_rdata"}, int'(bus.vga_rdata_o),    v.evd);
  endtask

  task automatic cycle_drive(input int gr, gw, ga, gd, vr, va, rd);
    @(posedge clk);
    #1;
    drive(gr, gw, ga, gd, vr, va, rd);
    @(negedge clk);
  endtask

  initial begin
    vec_t zero;
    zero = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0};

    //          gr gw ga       gd       vr va        rd       eg ev we oe ea        ed       egv egd      evv evd
    tbl[0]  = '{1, 1, 'h10,    'hABCD,  0, 0,        D,       1, 0, 0, 0, 0,        0,       0,  0,       0,  0};
    tbl[1]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 1, 0, 'h10,     'hABCD,  0,  0,       0,  0};
    tbl[2]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h10,     'hABCD,  0,  0,       0,  0};
    tbl[3]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h10,     'hABCD,  0,  0,       0,  0};
    tbl[4]  = '{0, 0, 0,       0,       1, 'h3FFFF,  D,       0, 1, 0, 0, 'h10,     'hABCD,  0,  0,       0,  0};
    tbl[5]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 1, 'h3FFFF,  'hABCD,  0,  0,       0,  0};
    tbl[6]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h3FFFF,  'hABCD,  0,  0,       0,  0};
    tbl[7]  = '{0, 0, 0,       0,       0, 0,        'h1234,  0, 0, 0, 0, 'h3FFFF,  'hABCD,  0,  0,       0,  0};
    tbl[8]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h3FFFF,  'hABCD,  0,  0,       1,  'h1234};
    tbl[9]  = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h3FFFF,  'hABCD,  0,  0,       0,  'h1234};
    tbl[10] = '{1, 0, 'h555,   0,       1, 'hAAA,    D,       0, 1, 0, 0, 'h3FFFF,  'hABCD,  0,  0,       0,  'h1234};
    tbl[11] = '{1, 0, 'h555,   0,       0, 0,        D,       1, 0, 0, 1, 'hAAA,    'hABCD,  0,  0,       0,  'h1234};
    tbl[12] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 1, 'h555,    'hABCD,  0,  0,       0,  'h1234};
    tbl[13] = '{0, 0, 0,       0,       0, 0,        'hBEEF,  0, 0, 0, 0, 'h555,    'hABCD,  0,  0,       0,  'h1234};
    tbl[14] = '{0, 0, 0,       0,       0, 0,        'hCAFE,  0, 0, 0, 0, 'h555,    'hABCD,  0,  0,       1,  'hBEEF};
    tbl[15] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h555,    'hABCD,  1,  'hCAFE,  0,  'hBEEF};
    tbl[16] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h555,    'hABCD,  0,  'hCAFE,  0,  'hBEEF};
    tbl[17] = '{1, 1, 'h20,    'h5A5A,  0, 0,        D,       1, 0, 0, 0, 'h555,    'hABCD,  0,  'hCAFE,  0,  'hBEEF};
    tbl[18] = '{0, 0, 0,       0,       1, 'h30,     D,       0, 0, 1, 0, 'h20,     'h5A5A,  0,  'hCAFE,  0,  'hBEEF};
    tbl[19] = '{0, 0, 0,       0,       1, 'h30,     D,       0, 1, 0, 0, 'h20,     'h5A5A,  0,  'hCAFE,  0,  'hBEEF};
    tbl[20] = '{1, 1, 'h40,    'h1111,  0, 0,        D,       1, 0, 0, 1, 'h30,     'h5A5A,  0,  'hCAFE,  0,  'hBEEF};
    tbl[21] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 1, 0, 'h40,     'h1111,  0,  'hCAFE,  0,  'hBEEF};
    tbl[22] = '{0, 0, 0,       0,       0, 0,        'h0F0F,  0, 0, 0, 0, 'h40,     'h1111,  0,  'hCAFE,  0,  'hBEEF};
    tbl[23] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h40,     'h1111,  0,  'hCAFE,  1,  'h0F0F};
    tbl[24] = '{1, 1, 'h50,    'h2222,  0, 0,        D,       1, 0, 0, 0, 'h40,     'h1111,  0,  'hCAFE,  0,  'h0F0F};
    tbl[25] = '{1, 1, 'h51,    'h3333,  0, 0,        D,       1, 0, 1, 0, 'h50,     'h2222,  0,  'hCAFE,  0,  'h0F0F};
    tbl[26] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 1, 0, 'h51,     'h3333,  0,  'hCAFE,  0,  'h0F0F};
    tbl[27] = '{0, 0, 0,       0,       0, 0,        D,       0, 0, 0, 0, 'h51,     'h3333,  0,  'hCAFE,  0,  'h0F0F};

    // Reset state: requests asserted while reset is held must not be granted.
    drive(1, 1, 'h10, 'h1, 1, 'h20, D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", zero);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, D);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].gr, tbl[i].gw, tbl[i].ga, tbl[i].gd, tbl[i].vr, tbl[i].va, tbl[i].rd);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Starvation: continuous VGA traffic against a held GPU write.
    repeat (3) cycle_drive(0, 0, 0, 0, 0, 0, D);
    for (int k = 0; k < 8; k++) begin
      cycle_drive(1, 1, 'h77, 'h7777, 1, 'h100 + k, D);
      chk($sformatf("starve%0d vga_gnt", k), int'(bus.vga_gnt_o), 1);
      chk($sformatf("starve%0d gpu_gnt", k), int'(bus.gpu_gnt_o), 0);
    end
    cycle_drive(1, 1, 'h77, 'h7777, 1, 'h108, D);
    chk("starve8 gpu_gnt", int'(bus.gpu_gnt_o), 1);
    chk("starve8 vga_gnt", int'(bus.vga_gnt_o), 0);
    cycle_drive(0, 0, 0, 0, 1, 'h108, D);
    chk("starve9 wait_cnt", int'(dut.r_wait_cnt), 0);
    chk("starve9 turn gnt", int'(bus.vga_gnt_o) + int'(bus.gpu_gnt_o), 0);
    chk("starve9 sram_we", int'(bus.sram_we_o), 1);
    chk("starve9 sram_addr", int'(bus.sram_addr_o), 'h77);
    chk("starve9 sram_wdata", int'(bus.sram_wdata_o), 'h7777);
    cycle_drive(0, 0, 0, 0, 1, 'h108, D);
    chk("starve10 vga_gnt", int'(bus.vga_gnt_o), 1);
    repeat (6) cycle_drive(0, 0, 0, 0, 0, 0, D);

    // Reset while a VGA read is in flight.
    cycle_drive(0, 0, 0, 0, 1, 'h123, D);
    chk("rstrd gnt", int'(bus.vga_gnt_o), 1);
    cycle_drive(0, 0, 0, 0, 0, 0, D);
    chk("rstrd oe", int'(bus.sram_oe_o), 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 'h9999);
    rst = 1'b1;
    #1;
    chk_all("rstrd async", zero);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rstrd quiet%0d vga_vld", k), int'(bus.vga_rd_valid_o), 0);
      chk($sformatf("rstrd quiet%0d gpu_vld", k), int'(bus.gpu_rd_valid_o), 0);
    end
    cycle_drive(0, 0, 0, 0, 1, 'h124, D);
    chk("post gnt", int'(bus.vga_gnt_o), 1);
    cycle_drive(0, 0, 0, 0, 0, 0, D);
    chk("post oe", int'(bus.sram_oe_o), 1);
    chk("post addr", int'(bus.sram_addr_o), 'h124);
    cycle_drive(0, 0, 0, 0, 0, 0, D);
    cycle_drive(0, 0, 0, 0, 0, 0, 'h4321);
    chk("post early vld", int'(bus.vga_rd_valid_o), 0);
    cycle_drive(0, 0, 0, 0, 0, 0, D);
    chk("post vga_vld", int'(bus.vga_rd_valid_o), 1);
    chk("post vga_rdata", int'(bus.vga_rdata_o), 'h4321);
    chk("post gpu_vld", int'(bus.gpu_rd_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
